// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB writeback stage: writeback source and load type encodings.
package wb_pkg;

  typedef enum logic [1:0] {
    ALU  = 2'd0,
    LOAD = 2'd1,
    LINK = 2'd2
  } wb_sel_t;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4
  } load_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Little-endian load data alignment with sign/zero extension for word, halfword and byte loads.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] readData,
  input  logic [1:0]  offset,
  input  logic [2:0]  loadType,
  output logic [31:0] aligned
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  // offset[0] is ignored for halfwords; misaligned halfwords are not trapped
  assign half = offset[1] ? readData[31:16] : readData[15:0];

  always_comb begin
    byte_sel = readData[7:0];
    case (offset)
      2'd1:    byte_sel = readData[15:8];
      2'd2:    byte_sel = readData[23:16];
      2'd3:    byte_sel = readData[31:24];
      default: byte_sel = readData[7:0];
    endcase
  end

  always_comb begin
    aligned = readData;
    case (loadType)
      LH:      aligned = {{16{half[15]}}, half};
      LHU:     aligned = {16'd0, half};
      LB:      aligned = {{24{byte_sel[7]}}, byte_sel};
      LBU:     aligned = {24'd0, byte_sel};
      default: aligned = readData;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback mux, load-wait stall, forwarding tap and retire counter.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memValid,
  input  logic              memRegWrite,
  input  logic [4:0]        memDest,
  input  logic [1:0]        memWbSel,
  input  logic [2:0]        memLoadType,
  input  logic [DATA_W-1:0] memAluResult,
  input  logic [DATA_W-1:0] memPc8,
  input  logic [DATA_W-1:0] readData,
  input  logic              readValid,
  input  logic              stallIn,
  input  logic              flushIn,
  output logic              wr,
  output logic [4:0]        writeAddr,
  output logic [DATA_W-1:0] in,
  output logic              stallOut,
  output logic              fwdValid,
  output logic [4:0]        fwdAddr,
  output logic [DATA_W-1:0] fwdData,
  output logic [31:0]       retireCount
);

  logic              valid_q;
  logic              reg_write_q;
  logic [4:0]        dest_q;
  logic [1:0]        wb_sel_q;
  logic [2:0]        load_type_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] pc8_q;
  logic [31:0]       retire_q;
  logic [DATA_W-1:0] load_data;
  logic              hold;
  logic              retire;

  assign stallOut = valid_q & (wb_sel_q == LOAD) & ~readValid;
  assign hold     = stallIn | stallOut;
  assign retire   = valid_q & ~stallOut & ~stallIn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      dest_q       <= REG_ZERO;
      wb_sel_q     <= ALU;
      load_type_q  <= LW;
      alu_result_q <= '0;
      pc8_q        <= '0;
    end else if (!hold) begin
      if (flushIn) begin
        valid_q <= 1'b0;
      end else begin
        valid_q      <= memValid;
        reg_write_q  <= memRegWrite;
        dest_q       <= memDest;
        wb_sel_q     <= memWbSel;
        load_type_q  <= memLoadType;
        alu_result_q <= memAluResult;
        pc8_q        <= memPc8;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) retire_q <= '0;
    else if (retire) retire_q <= retire_q + 32'd1;
  end

  load_align u_load_align (
    .readData (readData),
    .offset   (alu_result_q[1:0]),
    .loadType (load_type_q),
    .aligned  (load_data)
  );

  // reserved wbSel encoding falls back to the ALU result
  always_comb begin
    in = alu_result_q;
    case (wb_sel_q)
      LOAD:    in = load_data;
      LINK:    in = pc8_q;
      default: in = alu_result_q;
    endcase
  end

  assign wr          = valid_q & reg_write_q & (dest_q != REG_ZERO) & ~stallOut;
  assign writeAddr   = dest_q;
  assign fwdValid    = wr;
  assign fwdAddr     = writeAddr;
  assign fwdData     = in;
  assign retireCount = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: expected writes are queued at issue and popped when WB presents them.
module tb_writeback_stage;
  import wb_pkg::*;

  logic        clk, reset;
  logic        memValid, memRegWrite;
  logic [4:0]  memDest;
  logic [1:0]  memWbSel;
  logic [2:0]  memLoadType;
  logic [31:0] memAluResult, memPc8, readData;
  logic        readValid, stallIn, flushIn;
  logic        wr, stallOut, fwdValid;
  logic [4:0]  writeAddr, fwdAddr;
  logic [31:0] in, fwdData, retireCount;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_count = 0;

  writeback_stage #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .memValid(memValid), .memRegWrite(memRegWrite), .memDest(memDest),
    .memWbSel(memWbSel), .memLoadType(memLoadType), .memAluResult(memAluResult),
    .memPc8(memPc8), .readData(readData), .readValid(readValid),
    .stallIn(stallIn), .flushIn(flushIn),
    .wr(wr), .writeAddr(writeAddr), .in(in), .stallOut(stallOut),
    .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData),
    .retireCount(retireCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] d,
                       input logic [1:0] sel, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] pc8);
    memValid = v; memRegWrite = rw; memDest = d; memWbSel = sel;
    memLoadType = lt; memAluResult = alu; memPc8 = pc8;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 5'd0, ALU, LW, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (wr !== 1'b0 || stallOut !== 1'b0 || fwdValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: wr=%b stallOut=%b fwdValid=%b, required 0/0/0", wr, stallOut, fwdValid);
    end
    checks++;
    if (writeAddr !== 5'd0 || in !== 32'd0 || fwdAddr !== 5'd0 || fwdData !== 32'd0 || retireCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: writeAddr=%0d in=%h fwdAddr=%0d fwdData=%h retireCount=%0d, required all 0",
               writeAddr, in, fwdAddr, fwdData, retireCount);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b1, 5'd5, ALU, LW, 32'h1234, 32'h0);
    sb.push_back('{wr: 1'b1, addr: 5'd5, data: 32'h1234});
    step();
    bubble();
    e = sb.pop_front();
    checks++;
    if (wr !== e.wr || writeAddr !== e.addr || in !== e.data) begin
      errors++;
      $display("FAIL alu_write: wr=%b addr=%0d in=%h, required wr=%b addr=%0d in=%h", wr, writeAddr, in, e.wr, e.addr, e.data);
    end
    checks++;
    if (fwdValid !== e.wr || fwdAddr !== e.addr || fwdData !== e.data) begin
      errors++;
      $display("FAIL alu_fwd: fwdValid=%b fwdAddr=%0d fwdData=%h, required %b %0d %h", fwdValid, fwdAddr, fwdData, e.wr, e.addr, e.data);
    end
    step();
    exp_count++;
    checks++;
    if (retireCount !== exp_count) begin
      errors++;
      $display("FAIL alu_retire: retireCount=%0d, required %0d", retireCount, exp_count);
    end
  endtask

  task automatic test_byte_half_loads();
    logic [2:0]  lt[4]  = '{LB, LBU, LH, LHU};
    logic [1:0]  ofs[4] = '{2'd3, 2'd3, 2'd2, 2'd0};
    logic [31:0] res[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    readData = 32'h80FF7F01;
    readValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), LOAD, lt[i], {28'h0001000, 2'b00, ofs[i]}, 32'h0);
      sb.push_back('{wr: 1'b1, addr: 5'(i + 1), data: res[i]});
      step();
      e = sb.pop_front();
      checks++;
      if (wr !== e.wr || writeAddr !== e.addr || in !== e.data || stallOut !== 1'b0) begin
        errors++;
        $display("FAIL load_align[%0d]: wr=%b addr=%0d in=%h stallOut=%b, required wr=%b addr=%0d in=%h stallOut=0",
                 i, wr, writeAddr, in, stallOut, e.wr, e.addr, e.data);
      end
    end
    bubble();
    step();
    exp_count += 4;
    checks++;
    if (retireCount !== exp_count) begin
      errors++;
      $display("FAIL load_retire: retireCount=%0d, required %0d", retireCount, exp_count);
    end
    readValid = 1'b0;
  endtask

  task automatic test_load_wait();
    readValid = 1'b0;
    readData = 32'h0;
    drive(1'b1, 1'b1, 5'd7, LOAD, LW, 32'h100, 32'h0);
    sb.push_back('{wr: 1'b1, addr: 5'd7, data: 32'hDEADBEEF});
    step();
    // a different instruction waits in MEM; it must not be captured while held
    drive(1'b1, 1'b1, 5'd20, ALU, LW, 32'h5555, 32'h0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (stallOut !== 1'b1 || wr !== 1'b0 || retireCount !== exp_count || writeAddr !== 5'd7) begin
        errors++;
        $display("FAIL load_wait[%0d]: stallOut=%b wr=%b addr=%0d retireCount=%0d, required 1/0/7/%0d",
                 c, stallOut, wr, writeAddr, retireCount, exp_count);
      end
      step();
    end
    readValid = 1'b1;
    readData = 32'hDEADBEEF;
    #1;
    e = sb.pop_front();
    checks++;
    if (wr !== e.wr || writeAddr !== e.addr || in !== e.data || stallOut !== 1'b0) begin
      errors++;
      $display("FAIL load_arrive: wr=%b addr=%0d in=%h stallOut=%b, required wr=%b addr=%0d in=%h stallOut=0",
               wr, writeAddr, in, stallOut, e.wr, e.addr, e.data);
    end
    sb.push_back('{wr: 1'b1, addr: 5'd20, data: 32'h5555});
    step();
    bubble();
    readValid = 1'b0;
    exp_count++;
    e = sb.pop_front();
    checks++;
    if (wr !== e.wr || writeAddr !== e.addr || in !== e.data || retireCount !== exp_count) begin
      errors++;
      $display("FAIL load_release: wr=%b addr=%0d in=%h count=%0d, required wr=%b addr=%0d in=%h count=%0d",
               wr, writeAddr, in, retireCount, e.wr, e.addr, e.data, exp_count);
    end
    step();
    exp_count++;
  endtask

  task automatic test_zero_and_link();
    drive(1'b1, 1'b1, 5'd0, ALU, LW, 32'hABCD, 32'h0);
    sb.push_back('{wr: 1'b0, addr: 5'd0, data: 32'hABCD});
    step();
    drive(1'b1, 1'b1, 5'd31, LINK, LW, 32'h9999, 32'h00400008);
    e = sb.pop_front();
    checks++;
    if (wr !== e.wr || writeAddr !== e.addr) begin
      errors++;
      $display("FAIL zero_dest: wr=%b addr=%0d, required wr=%b addr=%0d", wr, writeAddr, e.wr, e.addr);
    end
    sb.push_back('{wr: 1'b1, addr: 5'd31, data: 32'h00400008});
    step();
    bubble();
    e = sb.pop_front();
    checks++;
    if (wr !== e.wr || writeAddr !== e.addr || in !== e.data) begin
      errors++;
      $display("FAIL link: wr=%b addr=%0d in=%h, required wr=%b addr=%0d in=%h", wr, writeAddr, in, e.wr, e.addr, e.data);
    end
    step();
    exp_count += 2;
    checks++;
    if (retireCount !== exp_count) begin
      errors++;
      $display("FAIL zero_link_retire: retireCount=%0d, required %0d", retireCount, exp_count);
    end
  endtask

  task automatic test_combined_stall();
    readValid = 1'b1;
    readData = 32'hCAFEF00D;
    stallIn = 1'b1;
    // stallIn alone does not block the first capture only if hold is low; release it for the capture edge
    stallIn = 1'b0;
    drive(1'b1, 1'b1, 5'd3, LOAD, LW, 32'h200, 32'h0);
    step();
    bubble();
    stallIn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (wr !== 1'b1 || in !== 32'hCAFEF00D || writeAddr !== 5'd3 || retireCount !== exp_count) begin
        errors++;
        $display("FAIL combined_stall[%0d]: wr=%b addr=%0d in=%h count=%0d, required 1/3/cafef00d/%0d",
                 c, wr, writeAddr, in, retireCount, exp_count);
      end
      step();
    end
    stallIn = 1'b0;
    step();
    exp_count++;
    readValid = 1'b0;
    checks++;
    if (retireCount !== exp_count || wr !== 1'b0) begin
      errors++;
      $display("FAIL combined_release: retireCount=%0d wr=%b, required %0d/0", retireCount, wr, exp_count);
    end
  endtask

  task automatic test_flush_hold();
    flushIn = 1'b1;
    drive(1'b1, 1'b1, 5'd9, ALU, LW, 32'h77, 32'h0);
    step();
    flushIn = 1'b0;
    bubble();
    checks++;
    if (wr !== 1'b0) begin
      errors++;
      $display("FAIL flush: wr=%b, required 0", wr);
    end
    step();
    checks++;
    if (retireCount !== exp_count) begin
      errors++;
      $display("FAIL flush_retire: retireCount=%0d, required %0d", retireCount, exp_count);
    end
    readValid = 1'b0;
    drive(1'b1, 1'b1, 5'd10, LOAD, LW, 32'h300, 32'h0);
    sb.push_back('{wr: 1'b1, addr: 5'd10, data: 32'h11223344});
    step();
    flushIn = 1'b1;
    drive(1'b1, 1'b1, 5'd11, ALU, LW, 32'h88, 32'h0);
    step();
    checks++;
    if (stallOut !== 1'b1 || writeAddr !== 5'd10) begin
      errors++;
      $display("FAIL flush_during_wait: stallOut=%b addr=%0d, required 1/10", stallOut, writeAddr);
    end
    readValid = 1'b1;
    readData = 32'h11223344;
    #1;
    e = sb.pop_front();
    checks++;
    if (wr !== e.wr || writeAddr !== e.addr || in !== e.data) begin
      errors++;
      $display("FAIL held_load_write: wr=%b addr=%0d in=%h, required wr=%b addr=%0d in=%h", wr, writeAddr, in, e.wr, e.addr, e.data);
    end
    step();
    flushIn = 1'b0;
    bubble();
    readValid = 1'b0;
    exp_count++;
    checks++;
    if (wr !== 1'b0 || retireCount !== exp_count) begin
      errors++;
      $display("FAIL flush_after_wait: wr=%b count=%0d, required 0/%0d", wr, retireCount, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    readValid = 1'b0;
    drive(1'b1, 1'b1, 5'd12, LOAD, LW, 32'h400, 32'h0);
    step();
    bubble();
    reset = 1'b1;
    #1;
    exp_count = 0;
    checks++;
    if (wr !== 1'b0 || stallOut !== 1'b0 || retireCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: wr=%b stallOut=%b count=%0d, required 0/0/0", wr, stallOut, retireCount);
    end
    @(negedge clk);
    reset = 1'b0;
    readValid = 1'b1;
    readData = 32'h12345678;
    step();
    checks++;
    if (wr !== 1'b0 || retireCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_write: wr=%b count=%0d, required 0/0", wr, retireCount);
    end
    readValid = 1'b0;
    force dut.retire_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_q;
    drive(1'b1, 1'b1, 5'd4, ALU, LW, 32'h1, 32'h0);
    step();
    bubble();
    step();
    checks++;
    if (retireCount !== 32'd0) begin
      errors++;
      $display("FAIL retire_wrap: retireCount=%h, required 00000000", retireCount);
    end
  endtask

  initial begin
    reset = 1'b1;
    readData = 32'h0; readValid = 1'b0; stallIn = 1'b0; flushIn = 1'b0;
    bubble();
    test_reset();
    test_alu_write();
    test_byte_half_loads();
    test_load_wait();
    test_zero_and_link();
    test_combined_stall();
    test_flush_hold();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final (MEM/WB) pipeline stage of the MIPS core. It registers the instruction leaving the memory stage and aligns and sign-extends load data from data memory. It selects the writeback value and drives the register file write port (`wr`, `writeAddr`, `in`). It also stalls the pipeline while a load waits for memory, provides a forwarding tap, and counts retired instructions.

## Interface
Parameters:
- `DATA_W`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memValid`  in  1  a valid instruction is presented by MEM.
- `memRegWrite`  in  1  the instruction writes a register.
- `memDest`  in  5  destination register number.
- `memWbSel`  in  2  writeback source: ALU, LOAD or LINK (`wb_sel_t`).
- `memLoadType`  in  3  load type: LW, LH, LHU, LB or LBU (`load_t`).
- `memAluResult`  in  32  ALU result; for loads, the byte address.
- `memPc8`  in  32  PC+8, used as the link value.
- `readData`  in  32  data memory read word.
- `readValid`  in  1  `readData` is valid for the load held in WB.
- `stallIn`  in  1  hold request from the hazard unit.
- `flushIn`  in  1  capture a bubble instead of the MEM instruction.
- `wr`  out  1  register file write enable.
- `writeAddr`  out  5  register file write address.
- `in`  out  32  register file write data.
- `stallOut`  out  1  WB is waiting for load data; upstream must freeze.
- `fwdValid`  out  1  the forwarding tap is valid; always equals `wr`.
- `fwdAddr`  out  5  forwarding register number; equals `writeAddr`.
- `fwdData`  out  32  forwarding data; equals `in`.
- `retireCount`  out  32  number of instructions retired.

## Operation
- **WB register contents:** valid, regWrite, dest, wbSel, loadType, aluResult, pc8.
- **hold:** `hold = stallIn | stallOut`.
- **Capture rule:**
  - If `hold` is high, the WB register keeps its value.
  - Else if `flushIn` is high, valid←0 and the other fields are don't-care.
  - Else the WB register captures the MEM inputs.
  - `flushIn` is ignored while `hold` is high; the controller must keep `flushIn` asserted until it takes effect.
- **stallOut:** `valid & wbSel==LOAD & !readValid`. It is combinational and has no registered state.
- **wr:** `valid & regWrite & dest!=0 & !stallOut`.
- **writeAddr:** equals dest.
- **in, by wbSel:**
  - ALU → aluResult.
  - LINK → pc8.
  - LOAD → aligned load data.
  - Reserved wbSel value → aluResult.
- **Load alignment** (little-endian, byte offset `a = aluResult[1:0]`):
  - LW: readData, with `a` ignored.
  - LH / LHU: halfword `readData[16*a[1] +: 16]`, sign-extended (LH) or zero-extended (LHU). `a[0]` is ignored; misaligned halfwords are not trapped.
  - LB / LBU: byte `readData[8*a +: 8]`, sign-extended (LB) or zero-extended (LBU).
  - Undefined loadType: treated as LW.
- **retireCount:**
  - Increments by 1 on each rising edge where `valid & !stallOut & !stallIn`, i.e. the WB instruction leaves the stage.
  - A write to `$0` still counts as retired.
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- **Latency:** MEM inputs appear on `wr`/`writeAddr`/`in` one cycle after capture. The outputs are combinational from the WB register and `readData`/`readValid`, so the register file writes on the following edge.
- **Reset values:**
  - valid=0, so `wr`=0, `stallOut`=0, `fwdValid`=0.
  - `writeAddr`=0, `in`=0, `fwdAddr`=0, `fwdData`=0.
  - `retireCount`=0.
  - Asserting `reset` mid-load drops the pending load; no write occurs.
- **Load wait:**
  - While `stallOut` is high, `wr`=0 and the WB register and `retireCount` are held.
  - In the cycle `readValid` rises, `wr` is asserted and the instruction retires on that edge.
- **Combined stall:** with `stallIn` and `readValid` both high, `wr` is asserted every cycle the instruction is held. The repeated write is idempotent; retire waits until `stallIn` drops.
- **Combinational path:** `readValid`→`stallOut` is combinational. The upstream freeze logic must not feed `readValid`.

## Structure
- Package `wb_pkg`:
  - `wb_sel_t` enum: ALU=0, LOAD=1, LINK=2.
  - `load_t` enum: LW=0, LH=1, LHU=2, LB=3, LBU=4.
  - `REG_ZERO = 5'd0`.
- Sub-module `load_align` (combinational): inputs readData, offset and loadType; output the 32-bit aligned value.
- Top level contains the WB register, the writeback mux, the stall logic and the retire counter.

## Test plan
- **ALU write:** memValid=1, regWrite=1, dest=5, wbSel=ALU, aluResult=0x1234 → next cycle `wr`=1, `writeAddr`=5, `in`=0x1234; `retireCount` reaches 1 after that edge.
- **Byte/halfword loads:** readData=0x80FF7F01, readValid=1:
  - LB, a=3 → `in`=0xFFFFFF80.
  - LBU, a=3 → `in`=0x80.
  - LH, a=2 → `in`=0xFFFF80FF.
  - LHU, a=0 → `in`=0x7F01.
- **Load wait:** LW with readValid low for 3 cycles → `stallOut`=1 and `wr`=0 for 3 cycles, `retireCount` unchanged. Then readValid=1 with readData=0xDEADBEEF → `wr`=1, `in`=0xDEADBEEF, `stallOut`=0, count+1.
- **$0 and link:** dest=0, regWrite=1 → `wr`=0, count still +1. A LINK with pc8=0x400008 and dest=31 → `in`=0x400008, `wr`=1.
- **Flush and hold:**
  - flushIn=1 while not held → next cycle `wr`=0, count unchanged.
  - flushIn=1 during a load wait → the held load still writes when readValid rises.
- **Reset mid-operation:** assert reset while a load waits → `wr`/`stallOut`/`retireCount` go to 0 immediately; no write after release. Also preload retireCount to 0xFFFFFFFF (force), then retire one instruction → 0.
